// File: rtl/gobou_pkg.sv
// Shared FSM encoding and pipeline latencies for the gobou MAC lane controller.
package gobou_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_GAP   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam int unsigned MAC_LAT  = 3;
  localparam int unsigned MEM_LAT  = 1;
  localparam int unsigned STRB_DLY = MEM_LAT + MAC_LAT;

endpackage

// File: rtl/gobou_strobe_dly.sv
// Fixed-depth shift line carrying issue strobes alongside the memory + MAC pipeline.
module gobou_strobe_dly #(
  parameter int unsigned W     = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         xrst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] sr [DEPTH];

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      for (int unsigned j = 0; j < DEPTH; j++) sr[j] <= '0;
    end else begin
      sr[0] <= din;
      for (int unsigned j = 1; j < DEPTH; j++) sr[j] <= sr[j-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/gobou_mac_ctrl.sv
// Sequencer for one gobou MAC lane: issues x/w reads per neuron and times the MAC strobes.
// Optional read-issue stall port enabled by defining GOBOU_CTRL_STALL_EN.
module gobou_mac_ctrl
  import gobou_pkg::*;
#(
  parameter int unsigned N_W     = 12,
  parameter int unsigned M_W     = 10,
  parameter int unsigned WADDR_W = 22
) (
  input  logic               clk,
  input  logic               xrst,
  input  logic               req,
  input  logic [N_W-1:0]     in_size,
  input  logic [M_W-1:0]     out_size,
`ifdef GOBOU_CTRL_STALL_EN
  input  logic               stall,
`endif
  output logic               busy,
  output logic               done,
  output logic               mem_re,
  output logic [N_W-1:0]     mem_x_addr,
  output logic [WADDR_W-1:0] mem_w_addr,
  output logic               mac_reset,
  output logic               mac_accum_we,
  output logic               mac_out_en,
  output logic               out_valid,
  output logic [M_W-1:0]     out_addr
);

  localparam int unsigned LINE_W = M_W + 2;

  state_t             state_q, state_d;
  logic [N_W-1:0]     n_q, n_d, i_d;
  logic [M_W-1:0]     m_q, m_d, k_q, k_d, k_oe_q;
  logic [WADDR_W-1:0] w_d;
  logic               hold_c, issue_c, last_c, accept_c, empty_job_c;
  logic [LINE_W-1:0]  line_in, line_out;

`ifdef GOBOU_CTRL_STALL_EN
  assign hold_c = stall;
`else
  assign hold_c = 1'b0;
`endif

  assign issue_c     = (state_q == S_RUN) && !hold_c;
  assign last_c      = issue_c && (mem_x_addr == n_q - N_W'(1));
  assign accept_c    = (state_q == S_IDLE) && req;
  assign empty_job_c = (in_size == '0) || (out_size == '0);
  assign mem_re      = issue_c;

  // Next-state and counter update; the gap cycle keeps mac_reset off data cycles.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    m_d     = m_q;
    i_d     = mem_x_addr;
    w_d     = mem_w_addr;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c && !empty_job_c) begin
          state_d = S_RUN;
          n_d     = in_size;
          m_d     = out_size;
          i_d     = '0;
          w_d     = '0;
          k_d     = '0;
        end
      end
      S_RUN: begin
        if (issue_c) begin
          w_d = mem_w_addr + WADDR_W'(1);
          if (last_c) begin
            i_d     = '0;
            state_d = (k_q == m_q - M_W'(1)) ? S_DRAIN : S_GAP;
          end else begin
            i_d = mem_x_addr + N_W'(1);
          end
        end
      end
      S_GAP: begin
        k_d     = k_q + M_W'(1);
        state_d = S_RUN;
      end
      S_DRAIN: begin
        if (done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The line plus the out_en/reset flops below form the STRB_DLY+1 deep strobe path.
  assign line_in = {issue_c, last_c, k_q};

  gobou_strobe_dly #(
    .W     (LINE_W),
    .DEPTH (STRB_DLY)
  ) u_dly (
    .clk  (clk),
    .xrst (xrst),
    .din  (line_in),
    .dout (line_out)
  );

  assign mac_accum_we = line_out[LINE_W-1];

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      m_q        <= '0;
      k_q        <= '0;
      k_oe_q     <= '0;
      mem_x_addr <= '0;
      mem_w_addr <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mac_reset  <= 1'b0;
      mac_out_en <= 1'b0;
      out_valid  <= 1'b0;
      out_addr   <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      m_q        <= m_d;
      k_q        <= k_d;
      mem_x_addr <= i_d;
      mem_w_addr <= w_d;
      busy       <= (state_d != S_IDLE);
      mac_out_en <= line_out[LINE_W-2];
      mac_reset  <= line_out[LINE_W-2] | (accept_c & ~empty_job_c);
      k_oe_q     <= line_out[M_W-1:0];
      out_valid  <= mac_out_en;
      out_addr   <= k_oe_q;
      done       <= (mac_out_en && (k_oe_q == m_q - M_W'(1))) || (accept_c && empty_job_c);
    end
  end

endmodule
